// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver FSM state type and default frame/oversample constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a. The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for Rx plus rising-edge detector for Sample_clock.
// Latency: Rx -> rx_s 2 cycles; tick is combinational from Sample_clock and its registered copy.
// Backpressure: none; free running.
// Ports: Sys_clock/reset (async, active high); Sample_clock, Rx in; rx_s, tick out.
module uart_rx_sync (
    input  logic Sys_clock,
    input  logic reset,
    input  logic Sample_clock,
    input  logic Rx,
    output logic rx_s,
    output logic tick
);

    logic rx_meta;
    logic sample_clock_d;

    // Flops reset high so an idle line and a held-high strobe do not
    // produce a spurious start or tick when reset releases.
    always_ff @(posedge Sys_clock or posedge reset) begin
        if (reset) begin
            rx_meta        <= 1'b1;
            rx_s           <= 1'b1;
            sample_clock_d <= 1'b1;
        end else begin
            rx_meta        <= Rx;
            rx_s           <= rx_meta;
            sample_clock_d <= Sample_clock;
        end
    end

    assign tick = Sample_clock & ~sample_clock_d;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, LSB-first data, optional even parity, stop) with a one-entry holding register.
// Latency: Rx_valid rises on the edge ending the stop-sample tick (tick OVERSAMPLE/2 + OVERSAMPLE*(frame bits-1) after start detect).
// Backpressure: none on the line; a frame completing while the holding register is full and unread is dropped and sets sticky Overrun.
// Ports: Sys_clock, reset (async, active high), Sample_clock, Rx, Rx_read in;
//        Rx_data, Rx_valid, Framing_error, Parity_error, Overrun, Busy out.
// Optional feature macro: UART_RX_PARITY_EN (adds the parity bit and makes Parity_error live).
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 Sys_clock,
    input  logic                 reset,
    input  logic                 Sample_clock,
    input  logic                 Rx,
    input  logic                 Rx_read,
    output logic [DATA_BITS-1:0] Rx_data,
    output logic                 Rx_valid,
    output logic                 Framing_error,
    output logic                 Parity_error,
    output logic                 Overrun,
    output logic                 Busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    logic rx_s;
    logic tick;

    uart_rx_sync u_sync (
        .Sys_clock    (Sys_clock),
        .reset        (reset),
        .Sample_clock (Sample_clock),
        .Rx           (Rx),
        .rx_s         (rx_s),
        .tick         (tick)
    );

    uart_rx_state_t       state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_done;
    logic                 frame_fe;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
`endif

    always_ff @(posedge Sys_clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Every transition and sample is qualified by tick; the counter counts
    // ticks within the current bit and wraps to 0 at each sample point.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        frame_done = 1'b0;
        frame_fe   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
`endif
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        // Line back high at mid start bit: glitch, not a frame.
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_d          = '0;
                        shift_d[idx_q] = rx_s;
                        if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_d   = '0;
                        // Even parity: any nonzero XOR over data+parity is an error.
                        par_d   = (^shift_q) ^ rx_s;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == CNT_BIT) begin
                        cnt_d      = '0;
                        frame_done = 1'b1;
                        frame_fe   = ~rx_s;
                        // A low stop (break) is re-seen as a start on the next tick.
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A read in the completion cycle frees the slot, so the new frame loads.
    logic can_load;
    assign can_load = ~Rx_valid | Rx_read;

    always_ff @(posedge Sys_clock or posedge reset) begin
        if (reset) begin
            Rx_data       <= '0;
            Rx_valid      <= 1'b0;
            Framing_error <= 1'b0;
            Overrun       <= 1'b0;
        end else if (frame_done) begin
            if (can_load) begin
                Rx_data       <= shift_q;
                Rx_valid      <= 1'b1;
                Framing_error <= frame_fe;
                Overrun       <= 1'b0;
            end else begin
                Overrun <= 1'b1;
            end
        end else if (Rx_valid && Rx_read) begin
            Rx_valid      <= 1'b0;
            Framing_error <= 1'b0;
            Overrun       <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge Sys_clock or posedge reset) begin
        if (reset) begin
            Parity_error <= 1'b0;
        end else if (frame_done) begin
            if (can_load) begin
                Parity_error <= par_q;
            end
        end else if (Rx_valid && Rx_read) begin
            Parity_error <= 1'b0;
        end
    end
`else
    assign Parity_error = 1'b0;
`endif

    assign Busy = (state_q != IDLE);

endmodule
